// File: rtl/regfile_bus.sv
// Byte-addressable register file with even/odd pair access (load/inc/dec) and tri-state byte and pair read ports.
// Optional macro REGFILE_WRAP_FLAG_EN adds a registered pair_wrap pulse on increment/decrement wrap-around.
module regfile_bus #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int SELW = $clog2(DEPTH),
  localparam int PSELW = ($clog2(DEPTH / 2) > 1) ? $clog2(DEPTH / 2) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SELW-1:0]    sel,
  input  logic               wenable,
  input  logic               oenable,
  input  logic [WIDTH-1:0]   in,
  output tri   [WIDTH-1:0]   out,
  input  logic [PSELW-1:0]   pair_sel,
  input  logic [1:0]         pair_op,
  input  logic [2*WIDTH-1:0] pair_in,
  input  logic               pair_oenable,
`ifdef REGFILE_WRAP_FLAG_EN
  output logic               pair_wrap,
`endif
  output tri   [2*WIDTH-1:0] pair_out
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;
  localparam logic [2*WIDTH-1:0] PAIR_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   regs_r      [DEPTH];
  logic [WIDTH-1:0]   regs_next_s [DEPTH];
  logic [WIDTH-1:0]   rd_s;
  logic [2*WIDTH-1:0] pair_cur_s;
  logic [2*WIDTH-1:0] pair_val_s;
  logic               pair_active_s;

  // Combinational read of the selected byte and pair; unmatched selects read as zero.
  always_comb begin
    rd_s = '0;
    pair_cur_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_s = (int'(sel) == i) ? regs_r[i] : rd_s;
    end
    for (int k = 0; k < DEPTH / 2; k++) begin
      pair_cur_s = (int'(pair_sel) == k) ? {regs_r[2*k], regs_r[2*k+1]} : pair_cur_s;
    end
  end

  assign out      = oenable      ? rd_s       : {WIDTH{1'bz}};
  assign pair_out = pair_oenable ? pair_cur_s : {(2*WIDTH){1'bz}};

  // Pair operation result computed on the full 2*WIDTH value so carries cross the byte boundary.
  always_comb begin
    pair_active_s = (pair_op != OP_NONE) && (int'(pair_sel) < DEPTH / 2);
    case (pair_op)
      OP_LOAD: pair_val_s = pair_in;
      OP_INC:  pair_val_s = pair_cur_s + PAIR_ONE;
      OP_DEC:  pair_val_s = pair_cur_s - PAIR_ONE;
      default: pair_val_s = pair_cur_s;
    endcase
  end

  // Next-state: a pair op owns both halves of its pair, so a byte write into that pair is dropped.
  always_comb begin
    regs_next_s = regs_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (pair_active_s && ((i / 2) == int'(pair_sel))) begin
        regs_next_s[i] = ((i % 2) == 0) ? pair_val_s[2*WIDTH-1:WIDTH] : pair_val_s[WIDTH-1:0];
      end else if (wenable && (int'(sel) == i)) begin
        regs_next_s[i] = in;
      end else begin
        regs_next_s[i] = regs_r[i];
      end
    end
  end

  // Register storage with asynchronous reset to RESET_VALUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= RESET_VALUE;
      end
    end else begin
      regs_r <= regs_next_s;
    end
  end

`ifdef REGFILE_WRAP_FLAG_EN
  logic wrap_next_s;

  // Wrap is detected on the pre-operation value: all-ones for increment, all-zeros for decrement.
  always_comb begin
    case (pair_op)
      OP_INC:  wrap_next_s = pair_active_s && (pair_cur_s == {(2*WIDTH){1'b1}});
      OP_DEC:  wrap_next_s = pair_active_s && (pair_cur_s == {(2*WIDTH){1'b0}});
      default: wrap_next_s = 1'b0;
    endcase
  end

  // One-cycle wrap pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_wrap <= 1'b0;
    end else begin
      pair_wrap <= wrap_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_bus.sv
// Directed self-checking bench for regfile_bus (default parameters: 8 x 8-bit registers, 4 pairs).
`timescale 1ns/1ps
module tb_regfile_bus;

  logic        clk;
  logic        rst;
  logic [2:0]  sel;
  logic        wenable;
  logic        oenable;
  logic [7:0]  in;
  wire  [7:0]  out;
  logic [1:0]  pair_sel;
  logic [1:0]  pair_op;
  logic [15:0] pair_in;
  logic        pair_oenable;
  wire  [15:0] pair_out;
`ifdef REGFILE_WRAP_FLAG_EN
  wire         pair_wrap;
`endif

  int checks = 0;
  int errors = 0;

  regfile_bus dut (
    .clk          (clk),
    .rst          (rst),
    .sel          (sel),
    .wenable      (wenable),
    .oenable      (oenable),
    .in           (in),
    .out          (out),
    .pair_sel     (pair_sel),
    .pair_op      (pair_op),
    .pair_in      (pair_in),
    .pair_oenable (pair_oenable),
`ifdef REGFILE_WRAP_FLAG_EN
    .pair_wrap    (pair_wrap),
`endif
    .pair_out     (pair_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Disabled port must not present the stored value (reads Z, or a pull value).
  task automatic chk_off(input string tag, input logic [15:0] obs, input logic [15:0] held);
    checks++;
    assert (obs !== held) else begin
      errors++;
      $error("FAIL %s: observed %h expected not-driven (not %h)", tag, obs, held);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 3'd0; wenable = 1'b0; oenable = 1'b1; in = 8'h00;
    pair_sel = 2'd0; pair_op = 2'b00; pair_in = 16'h0000; pair_oenable = 1'b0;
    #2;
    chk("reset_reg0", {8'h00, out}, 16'h0000);
    #20;
    rst = 1'b0;
    tick();

    // Fill every register with 0x5A.
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i); wenable = 1'b1; in = 8'h5A;
      tick();
    end
    wenable = 1'b0; sel = 3'd5;
    #1;
    chk("fill_reg5", {8'h00, out}, 16'h005A);
    pair_sel = 2'd2; pair_oenable = 1'b0;
    #1;
    chk_off("pair_out_disabled", pair_out, 16'h5A5A);

    // Asynchronous reset pulse between edges.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #1;
      chk($sformatf("async_reset_reg%0d", i), {8'h00, out}, 16'h0000);
    end

    // Reset held across an edge overrides a pending write.
    tick();
    sel = 3'd0; wenable = 1'b1; in = 8'h77; rst = 1'b1;
    tick();
    rst = 1'b0; wenable = 1'b0;
    #1;
    chk("reset_beats_write", {8'h00, out}, 16'h0000);

    // Byte writes and reads.
    sel = 3'd2; wenable = 1'b1; in = 8'h12;
    tick();
    sel = 3'd3; in = 8'h34;
    tick();
    wenable = 1'b0; sel = 3'd2;
    pair_sel = 2'd1; pair_oenable = 1'b1;
    #1;
    chk("byte_reg2", {8'h00, out}, 16'h0012);
    chk("pair1_bytes", pair_out, 16'h1234);
    oenable = 1'b0;
    #1;
    chk_off("out_disabled", {8'h00, out}, 16'h0012);
    oenable = 1'b1;

    // Read-before-write: old value until the edge.
    wenable = 1'b1; in = 8'h99;
    #1;
    chk("rbw_before_edge", {8'h00, out}, 16'h0012);
    tick();
    wenable = 1'b0;
    chk("rbw_after_edge", {8'h00, out}, 16'h0099);

    // Increment with carry and wrap on pair0.
    pair_sel = 2'd0; pair_op = 2'b01; pair_in = 16'h00FF;
    tick();
    chk("pair0_load", pair_out, 16'h00FF);
    pair_op = 2'b10;
    tick();
    chk("pair0_inc_carry", pair_out, 16'h0100);
    pair_op = 2'b01; pair_in = 16'hFFFF;
    tick();
    pair_op = 2'b10;
    tick();
    pair_op = 2'b00;
    chk("pair0_inc_wrap", pair_out, 16'h0000);
`ifdef REGFILE_WRAP_FLAG_EN
    chk("wrap_inc_pulse", {15'h0000, pair_wrap}, 16'h0001);
    tick();
    chk("wrap_inc_clear", {15'h0000, pair_wrap}, 16'h0000);
`endif

    // Decrement wrap on pair3.
    pair_sel = 2'd3; pair_op = 2'b01; pair_in = 16'h0000;
    tick();
    pair_op = 2'b11;
    tick();
    chk("pair3_dec_wrap", pair_out, 16'hFFFF);
`ifdef REGFILE_WRAP_FLAG_EN
    chk("wrap_dec_pulse", {15'h0000, pair_wrap}, 16'h0001);
`endif
    tick();
    pair_op = 2'b00;
    chk("pair3_dec_again", pair_out, 16'hFFFE);
`ifdef REGFILE_WRAP_FLAG_EN
    chk("wrap_dec_none", {15'h0000, pair_wrap}, 16'h0000);
`endif

    // Conflict: byte write inside the selected pair is dropped.
    pair_sel = 2'd1; pair_op = 2'b01; pair_in = 16'hAAAA;
    sel = 3'd3; wenable = 1'b1; in = 8'h55;
    tick();
    pair_op = 2'b00; wenable = 1'b0;
    chk("conflict_in_pair", pair_out, 16'hAAAA);
    chk("conflict_reg3", {8'h00, out}, 16'h00AA);
    // Byte write outside the selected pair proceeds alongside the pair op.
    pair_op = 2'b01; pair_in = 16'hAAAA;
    sel = 3'd4; wenable = 1'b1; in = 8'h55;
    tick();
    pair_op = 2'b00; wenable = 1'b0;
    chk("conflict_out_pair", pair_out, 16'hAAAA);
    chk("conflict_reg4", {8'h00, out}, 16'h0055);

    // Back-to-back increments on pair2.
    pair_sel = 2'd2; pair_op = 2'b01; pair_in = 16'h00FE;
    tick();
    pair_op = 2'b10;
    tick();
    chk("b2b_inc1", pair_out, 16'h00FF);
    tick();
    chk("b2b_inc2", pair_out, 16'h0100);
    tick();
    chk("b2b_inc3", pair_out, 16'h0101);
    tick();
    pair_op = 2'b00;
    chk("b2b_inc4", pair_out, 16'h0102);
    sel = 3'd4;
    #1;
    chk("b2b_high_byte", {8'h00, out}, 16'h0001);
    tick();
    chk("idle_holds", pair_out, 16'h0102);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
